feature_bank_loader: RTL

- Instruction-driven feature fetch engine feeding a parametrised set of scratchpad feature banks.
- Generalises the fixed two-bank ping-pong write path to NUM_BANKS banks with configurable external read latency.
- Adds per-bank ownership handshake with the compute side: a bank is never overwritten before the consumer releases it.
- Sits between instruction_decode (command side), the external data bus, and the scratchpad_feature_mem banks.

---
 rtl/feature_bank_loader.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/feature_bank_loader.sv
// feature_bank_loader: instruction-driven feature fetch engine that streams
// external bus words into one of NUM_BANKS scratchpad banks and tracks
// per-bank ownership with the compute side (full/release handshake).
// Optional feature macro: FEATURE_LOADER_PERF_EN (busy/stall cycle counters).
module feature_bank_loader #(
  parameter int DATA_BUS_WIDTH  = 128,
  parameter int EXT_ADDR_WIDTH  = 16,
  parameter int BANK_ADDR_WIDTH = 8,
  parameter int NUM_BANKS       = 2,
  parameter int BANK_SEL_WIDTH  = 3,
  parameter int LEN_WIDTH       = 8,
  parameter int RD_LATENCY      = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [EXT_ADDR_WIDTH-1:0]  cmd_src_addr,
  input  logic [BANK_ADDR_WIDTH-1:0] cmd_dst_addr,
  input  logic [BANK_SEL_WIDTH-1:0]  cmd_bank,
  input  logic [LEN_WIDTH-1:0]       cmd_len,
  output logic                       ext_rd_en,
  output logic [EXT_ADDR_WIDTH-1:0]  ext_rd_addr,
  input  logic [DATA_BUS_WIDTH-1:0]  ext_rd_data,
  output logic [NUM_BANKS-1:0]       bank_wr_en,
  output logic [BANK_ADDR_WIDTH-1:0] bank_wr_addr,
  output logic [DATA_BUS_WIDTH-1:0]  bank_wr_data,
  output logic [NUM_BANKS-1:0]       bank_full,
  input  logic [NUM_BANKS-1:0]       bank_release,
  output logic                       busy,
  output logic                       fetch_done,
  output logic                       cmd_err,
  output logic [31:0]                perf_busy_cycles,
  output logic [31:0]                perf_stall_cycles
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_WAIT_BANK, S_ISSUE, S_DRAIN, S_DONE
  } state_t;

  // Marks the oldest pipeline stage, whose entry is being written this cycle
  localparam logic [RD_LATENCY-1:0] LAST_STAGE = RD_LATENCY'(1) << (RD_LATENCY - 1);

  state_t                     r_state, w_nextState;
  logic [EXT_ADDR_WIDTH-1:0]  r_src;
  logic [BANK_ADDR_WIDTH-1:0] r_dst;
  logic [BANK_SEL_WIDTH-1:0]  r_bank;
  logic [LEN_WIDTH-1:0]       r_len;
  logic [LEN_WIDTH-1:0]       r_count;
  logic [NUM_BANKS-1:0]       r_full;
  logic                       r_err;
  logic [RD_LATENCY-1:0]      r_pipeValid;
  logic [BANK_ADDR_WIDTH-1:0] r_pipeAddr [RD_LATENCY];

  logic [NUM_BANKS-1:0]       w_bankOneHot;
  logic [NUM_BANKS-1:0]       w_setFull;
  logic                       w_accept;
  logic                       w_bankBad;
  logic                       w_targetFull;
  logic                       w_issue;
  logic                       w_lastIssue;
  logic                       w_pipeBusy;
  logic                       w_pipeOut;
  logic                       w_setErr;

  assign w_accept     = cmd_valid && (r_state == S_IDLE);
  assign w_bankBad    = 32'(r_bank) >= NUM_BANKS;
  assign w_targetFull = |(r_full & w_bankOneHot);
  assign w_issue      = (r_state == S_ISSUE);
  assign w_lastIssue  = (r_count == r_len - LEN_WIDTH'(1));
  assign w_pipeBusy   = |(r_pipeValid & ~LAST_STAGE);
  assign w_pipeOut    = r_pipeValid[RD_LATENCY-1];

  // Decode the latched bank index; out-of-range indices select no bank
  always_comb begin
    w_bankOneHot = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      w_bankOneHot[i] = (32'(r_bank) == i);
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_nextState;
  end

  // Next-state logic plus the one-cycle error and bank-set strobes
  always_comb begin
    w_nextState = r_state;
    w_setErr    = 1'b0;
    w_setFull   = '0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) w_nextState = S_CHECK;
      end
      S_CHECK: begin
        if (w_bankBad) begin
          w_setErr    = 1'b1;
          w_nextState = S_DONE;
        end else if (r_len == '0) begin
          w_nextState = S_DONE;
        end else if (w_targetFull) begin
          w_nextState = S_WAIT_BANK;
        end else begin
          w_nextState = S_ISSUE;
        end
      end
      S_WAIT_BANK: begin
        if (!w_targetFull) w_nextState = S_ISSUE;
      end
      S_ISSUE: begin
        if (w_lastIssue) w_nextState = S_DRAIN;
      end
      S_DRAIN: begin
        if (!w_pipeBusy) w_nextState = S_DONE;
      end
      S_DONE: begin
        if (r_len != '0) w_setFull = w_bankOneHot;
        w_nextState = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  // Latch command fields on acceptance
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_src  <= '0;
      r_dst  <= '0;
      r_bank <= '0;
      r_len  <= '0;
    end else if (w_accept) begin
      r_src  <= cmd_src_addr;
      r_dst  <= cmd_dst_addr;
      r_bank <= cmd_bank;
      r_len  <= cmd_len;
    end
  end

  // Word offset k: advances once per strobe, held at zero outside ISSUE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         r_count <= '0;
    else if (w_issue) r_count <= r_count + LEN_WIDTH'(1);
    else              r_count <= '0;
  end

  // Read-latency pipeline carrying (valid, dst + k) alongside the bus read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pipeValid <= '0;
      for (int i = 0; i < RD_LATENCY; i++) r_pipeAddr[i] <= '0;
    end else begin
      r_pipeValid[0] <= w_issue;
      r_pipeAddr[0]  <= r_dst + BANK_ADDR_WIDTH'(r_count);
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_pipeValid[i] <= r_pipeValid[i-1];
        r_pipeAddr[i]  <= r_pipeAddr[i-1];
      end
    end
  end

  // Bank ownership: release clears, completion sets, set wins on collision
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_full <= '0;
    else      r_full <= (r_full & ~bank_release) | w_setFull;
  end

  // Sticky error flag for out-of-range bank indices
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          r_err <= 1'b0;
    else if (w_setErr) r_err <= 1'b1;
  end

  assign cmd_ready    = (r_state == S_IDLE);
  assign busy         = (r_state != S_IDLE);
  assign fetch_done   = (r_state == S_DONE);
  assign cmd_err      = r_err;
  assign bank_full    = r_full;
  assign ext_rd_en    = w_issue;
  assign ext_rd_addr  = w_issue ? r_src + EXT_ADDR_WIDTH'(r_count) : '0;
  assign bank_wr_en   = w_pipeOut ? w_bankOneHot : '0;
  assign bank_wr_addr = w_pipeOut ? r_pipeAddr[RD_LATENCY-1] : '0;
  assign bank_wr_data = w_pipeOut ? ext_rd_data : '0;

`ifdef FEATURE_LOADER_PERF_EN
  logic [31:0] r_perfBusy;
  logic [31:0] r_perfStall;

  // Saturating busy and bank-stall cycle counters, cleared only by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perfBusy  <= '0;
      r_perfStall <= '0;
    end else begin
      if ((r_state != S_IDLE) && (r_perfBusy != '1))
        r_perfBusy <= r_perfBusy + 32'd1;
      if ((r_state == S_WAIT_BANK) && (r_perfStall != '1))
        r_perfStall <= r_perfStall + 32'd1;
    end
  end

  assign perf_busy_cycles  = r_perfBusy;
  assign perf_stall_cycles = r_perfStall;
`else
  assign perf_busy_cycles  = 32'd0;
  assign perf_stall_cycles = 32'd0;
`endif

endmodule
